// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 1-cycle-latency BRAM port between fetch and data requesters; optional ARB_RDATA_HOLD_EN keeps last read word per channel
module mem_port_arbiter #(
  parameter int AWIDTH         = 14,
  parameter int DWIDTH         = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_req,
  input  logic [AWIDTH-1:0]     f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [DWIDTH-1:0]     f_rdata,
  input  logic                  d_req,
  input  logic [DWIDTH/8-1:0]   d_we,
  input  logic [AWIDTH-1:0]     d_addr,
  input  logic [DWIDTH-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DWIDTH-1:0]     d_rdata,
  output logic                  mem_en,
  output logic [DWIDTH/8-1:0]   mem_we,
  output logic [AWIDTH-1:0]     mem_addr,
  output logic [DWIDTH-1:0]     mem_din,
  input  logic [DWIDTH-1:0]     mem_dout,
  output logic                  stall_fd
);
  localparam logic [3:0] MAXB = 4'(MAX_DATA_BURST);
  logic [3:0] r_burst;
  logic       r_rd_pending;
  logic       r_rd_owner;
  logic       w_f_win;
  logic       w_d_read;
  // grant selection and memory port drive; fetch wins when data is idle or has used its burst
  always_comb begin
    w_f_win  = f_req & (~d_req | (r_burst == MAXB));
    f_gnt    = ~rst & w_f_win;
    d_gnt    = ~rst & d_req & ~w_f_win;
    w_d_read = d_gnt & ~|d_we;
    stall_fd = ~rst & f_req & ~f_gnt;
    mem_en   = f_gnt | d_gnt;
    mem_we   = d_gnt ? d_we : '0;
    mem_addr = f_gnt ? f_addr : (d_gnt ? d_addr : '0);
    mem_din  = d_gnt ? d_wdata : '0;
  end
  // count data grants taken while fetch is waiting, saturating at the burst limit
  always_ff @(posedge clk) begin
    if (rst || !f_req || f_gnt) r_burst <= '0;
    else if (d_gnt && r_burst != MAXB) r_burst <= r_burst + 4'd1;
  end
  // tag the read issued this cycle so its data is routed to the owner next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pending <= 1'b0;
      r_rd_owner   <= 1'b0;
    end else begin
      r_rd_pending <= f_gnt | w_d_read;
      r_rd_owner   <= f_gnt;
    end
  end
  // a read in flight when reset arrives is dropped
  assign f_rvalid = ~rst & r_rd_pending & r_rd_owner;
  assign d_rvalid = ~rst & r_rd_pending & ~r_rd_owner;
`ifdef ARB_RDATA_HOLD_EN
  logic [DWIDTH-1:0] r_f_hold;
  logic [DWIDTH-1:0] r_d_hold;
  // keep the last returned word per channel so it stays stable across stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f_hold <= '0;
      r_d_hold <= '0;
    end else begin
      if (f_rvalid) r_f_hold <= mem_dout;
      if (d_rvalid) r_d_hold <= mem_dout;
    end
  end
  assign f_rdata = f_rvalid ? mem_dout : r_f_hold;
  assign d_rdata = d_rvalid ? mem_dout : r_d_hold;
`else
  assign f_rdata = mem_dout;
  assign d_rdata = mem_dout;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus read-return scoreboard for mem_port_arbiter
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, d_req;
  logic [13:0] f_addr, d_addr;
  logic [3:0]  d_we;
  logic [31:0] d_wdata;
  logic        f_gnt, f_rvalid, d_gnt, d_rvalid, mem_en, stall_fd;
  logic [31:0] f_rdata, d_rdata, mem_din, mem_dout;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic        init = 1'b0;
  logic [31:0] noise = '0;
  logic [31:0] mem [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic [31:0] r_dout = '0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic        f_req;
    logic [13:0] f_addr;
    logic        d_req;
    logic [3:0]  d_we;
    logic [13:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_f;
    logic        e_d;
  } vec_t;
  typedef struct {
    logic        own;
    logic [31:0] data;
  } sb_t;
  vec_t tv[$];
  sb_t  sb[$];

  mem_port_arbiter #(.AWIDTH(14), .DWIDTH(32), .MAX_DATA_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .stall_fd(stall_fd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [13:0] a);
    case (a)
      14'h010: return 32'h0000_0013;
      14'h040: return 32'h1122_3344;
      14'h080: return 32'hDEAD_BEEF;
      default: return {16'hC0DE, 2'b00, a};
    endcase
  endfunction

  // read-first byte-write BRAM with one cycle read latency
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 16384; i++) mem[i] <= init_val(14'(i));
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++) if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      r_dout <= mem[mem_addr];
    end
  end
  assign mem_dout = r_dout ^ noise;

  function automatic vec_t mk(input string nm, input logic r, input logic fr, input logic [13:0] fa,
                              input logic dr, input logic [3:0] we, input logic [13:0] da,
                              input logic [31:0] wd, input logic ef, input logic ed);
    vec_t v;
    v.name = nm; v.rst = r; v.f_req = fr; v.f_addr = fa; v.d_req = dr;
    v.d_we = we; v.d_addr = da; v.d_wdata = wd; v.e_f = ef; v.e_d = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    sb_t e;
    logic ef, ed;
    rst = v.rst; f_req = v.f_req; f_addr = v.f_addr; d_req = v.d_req;
    d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    @(negedge clk);
    chk({v.name, ".f_gnt"}, 32'(f_gnt), 32'(v.e_f));
    chk({v.name, ".d_gnt"}, 32'(d_gnt), 32'(v.e_d));
    chk({v.name, ".stall_fd"}, 32'(stall_fd), 32'(!v.rst && v.f_req && !v.e_f));
    chk({v.name, ".mem_en"}, 32'(mem_en), 32'(v.e_f || v.e_d));
    chk({v.name, ".mem_we"}, 32'(mem_we), 32'(v.e_d ? v.d_we : 4'h0));
    chk({v.name, ".mem_addr"}, 32'(mem_addr), 32'(v.e_f ? v.f_addr : (v.e_d ? v.d_addr : 14'h0)));
    if (v.e_d) chk({v.name, ".mem_din"}, mem_din, v.d_wdata);
    ef = 1'b0; ed = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      ef = !v.rst && e.own;
      ed = !v.rst && !e.own;
    end
    chk({v.name, ".f_rvalid"}, 32'(f_rvalid), 32'(ef));
    chk({v.name, ".d_rvalid"}, 32'(d_rvalid), 32'(ed));
    if (ef) chk({v.name, ".f_rdata"}, f_rdata, e.data);
    if (ed) chk({v.name, ".d_rdata"}, d_rdata, e.data);
    if (!v.rst) begin
      if (v.e_f) begin
        e.own = 1'b1; e.data = ref_mem[v.f_addr]; sb.push_back(e);
      end else if (v.e_d && v.d_we == 4'h0) begin
        e.own = 1'b0; e.data = ref_mem[v.d_addr]; sb.push_back(e);
      end else if (v.e_d) begin
        for (int b = 0; b < 4; b++) if (v.d_we[b]) ref_mem[v.d_addr][8*b +: 8] = v.d_wdata[8*b +: 8];
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    logic [31:0] exp_f;
    for (int i = 0; i < 16384; i++) ref_mem[i] = init_val(14'(i));
    rst = 1'b1; f_req = 1'b0; d_req = 1'b0; f_addr = '0; d_addr = '0; d_we = '0; d_wdata = '0;
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    for (int i = 0; i < 3; i++) tv.push_back(mk("rst_hold", 1, 1, 14'h010, 1, 4'h0, 14'h030, 0, 0, 0));
    tv.push_back(mk("t1_fetch", 0, 1, 14'h010, 0, 4'h0, 14'h000, 0, 1, 0));
    tv.push_back(mk("t2_cont", 0, 1, 14'h020, 1, 4'h0, 14'h030, 0, 0, 1));
    tv.push_back(mk("t2_fretry", 0, 1, 14'h020, 0, 4'h0, 14'h000, 0, 1, 0));
    tv.push_back(mk("t3_write", 0, 0, 14'h000, 1, 4'b0011, 14'h040, 32'hAABBCCDD, 0, 1));
    tv.push_back(mk("t3_fread", 0, 1, 14'h040, 0, 4'h0, 14'h000, 0, 1, 0));
    tv.push_back(mk("same_wr", 0, 1, 14'h050, 1, 4'hF, 14'h050, 32'h5A5A0050, 0, 1));
    tv.push_back(mk("same_retry", 0, 1, 14'h050, 0, 4'h0, 14'h000, 0, 1, 0));
    tv.push_back(mk("idle", 0, 0, 14'h000, 0, 4'h0, 14'h000, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      tv.push_back(mk("t4_starve", 0, 1, 14'h060, 1, 4'h0, 14'(14'h070 + i), 0, (i % 5) == 4, (i % 5) != 4));
    tv.push_back(mk("t5_grant", 0, 1, 14'h010, 0, 4'h0, 14'h000, 0, 1, 0));
    tv.push_back(mk("t5_rst", 1, 1, 14'h010, 1, 4'h0, 14'h030, 0, 0, 0));
    for (int i = 0; i < 3; i++) tv.push_back(mk("t5_prefill", 0, 1, 14'h060, 1, 4'h0, 14'h070, 0, 0, 1));
    tv.push_back(mk("t5_rst2", 1, 1, 14'h060, 1, 4'h0, 14'h070, 0, 0, 0));
    for (int i = 0; i < 5; i++) tv.push_back(mk("t5_cnt_clr", 0, 1, 14'h060, 1, 4'h0, 14'h071, 0, i == 4, i != 4));
    tv.push_back(mk("idle", 0, 0, 14'h000, 0, 4'h0, 14'h000, 0, 0, 0));
    foreach (tv[i]) apply(tv[i]);
    apply(mk("t6_fetch", 0, 1, 14'h080, 0, 4'h0, 14'h000, 0, 1, 0));
    apply(mk("t6_ret", 0, 0, 14'h000, 0, 4'h0, 14'h000, 0, 0, 0));
    v = mk("t6_idle", 0, 0, 14'h000, 0, 4'h0, 14'h000, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      noise = $urandom | 32'h1;
      rst = v.rst; f_req = v.f_req; d_req = v.d_req;
      @(negedge clk);
`ifdef ARB_RDATA_HOLD_EN
      exp_f = 32'hDEADBEEF;
`else
      exp_f = 32'hDEADBEEF ^ noise;
`endif
      chk("t6_hold.f_rdata", f_rdata, exp_f);
      chk("t6_hold.f_rvalid", 32'(f_rvalid), 32'h0);
      @(posedge clk); #1;
    end
    noise = '0;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous-read BRAM port (IMEM/BIOS style, 1-cycle read latency) between two requesters: instruction fetch (FD stage) and data access (MW stage).
- Grants at most one requester per cycle and drives the memory port.
- Returns read data to the owning requester one cycle later, with owner tagging.
- Raises a fetch stall to the pipeline when fetch is denied; a bounded-burst counter prevents fetch starvation.

Parameters:
- AWIDTH, 14, word-address width of the shared port
- DWIDTH, 32, data width
- MAX_DATA_BURST, 4, max consecutive data grants while fetch waits before fetch is forced through (range 1..15)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- f_req  input  1  fetch read request; held until f_gnt
- f_addr  input  AWIDTH  fetch word address
- f_gnt  output  1  fetch granted this cycle
- f_rvalid  output  1  fetch read data valid
- f_rdata  output  DWIDTH  fetch read data
- d_req  input  1  data request; held with stable addr/we/wdata until d_gnt
- d_we  input  DWIDTH/8  byte write enables; zero means read
- d_addr  input  AWIDTH  data word address
- d_wdata  input  DWIDTH  store data
- d_gnt  output  1  data granted this cycle
- d_rvalid  output  1  data read data valid (reads only)
- d_rdata  output  DWIDTH  data read data
- mem_en  output  1  memory port enable
- mem_we  output  DWIDTH/8  memory byte write enables
- mem_addr  output  AWIDTH  memory address
- mem_din  output  DWIDTH  memory write data
- mem_dout  input  DWIDTH  memory read data, valid the cycle after the read is issued
- stall_fd  output  1  f_req asserted and not granted this cycle

Behaviour:
- Grant logic is combinational from req inputs and the burst counter. At most one of f_gnt and d_gnt is high.
- Priority: data wins by default. Fetch wins when f_req=1 and either d_req=0 or burst_cnt==MAX_DATA_BURST.
- Memory drive on grant:
  - mem_en=1; mem_addr = granted address.
  - Fetch grant: mem_we=0.
  - Data grant: mem_we=d_we and mem_din=d_wdata.
  - No grant: mem_en=0, mem_we=0; addr and din don't-care but driven to 0.
- burst_cnt (4-bit):
  - Increments on a data grant while f_req=1.
  - Clears on any fetch grant, or in any cycle with f_req=0.
  - Saturates at MAX_DATA_BURST.
- Read return pipeline: registered owner tag {rd_pending, rd_owner}, set on any read grant (fetch, or data with d_we==0).
  - Next cycle: f_rvalid=1 when owner=fetch; d_rvalid=1 when owner=data.
  - The owning rdata equals mem_dout.
  - Writes never produce rvalid.
- Back-to-back reads are sustained: one grant per cycle, one rvalid per cycle, with no bubbles.
- Read latency is exactly 1 cycle from grant to rvalid.
- stall_fd = f_req & ~f_gnt, combinational.
- Reset (rst=1):
  - f_gnt, d_gnt, mem_en, mem_we, stall_fd all 0 during reset, regardless of req.
  - f_rvalid, d_rvalid 0 in the cycle after reset is sampled.
  - burst_cnt=0, rd_pending=0.
  - A read granted the cycle before rst is asserted produces no rvalid.
- Simultaneous requests to the same address: data wins (unless the burst limit applies). Fetch retries and, if the data op was a write, observes the written value.
- Requesters that drop req before grant are legal; no state is retained for them.
- f_rdata/d_rdata when not valid: see Optional Feature.

Optional Feature:
- Macro ARB_RDATA_HOLD_EN.
- Defined: each channel has a DWIDTH holding register that captures mem_dout whenever its rvalid is 1 (reset 0). Xrdata = rvalid ? mem_dout : held value, so the last returned word remains stable across stalls.
- Undefined: f_rdata = d_rdata = mem_dout directly; content is meaningful only while the corresponding rvalid=1.

Test Plan:
1. Reset, then a read:
   - Stimulus: rst high 3 cycles with f_req=d_req=1.
   - Required: all grants, mem_en and rvalids are 0.
   - Then f_req=1, f_addr=0x010, memory word 0x00000013 at 0x010.
   - Required: f_gnt same cycle; f_rvalid=1 and f_rdata=0x00000013 next cycle.
2. Contention:
   - Stimulus: f_req=1 (addr 0x020), d_req=1, d_we=0, d_addr=0x030 in the same cycle.
   - Required: d_gnt=1, f_gnt=0, stall_fd=1; next cycle d_rvalid=1 with mem[0x030], f_rvalid=0.
   - After d_req drops: fetch granted.
3. Write then read:
   - Stimulus: d_we=4'b0011, d_addr=0x040, d_wdata=0xAABBCCDD over old 0x11223344.
   - Required: mem_we=4'b0011 and no d_rvalid.
   - A subsequent fetch of 0x040 returns 0x1122CCDD.
4. Starvation guard:
   - Stimulus: d_req held high with reads for 10 cycles, f_req high throughout, MAX_DATA_BURST=4.
   - Required: grant pattern D,D,D,D,F,D,D,D,D,F; stall_fd low exactly on the F cycles.
5. Reset mid-read:
   - Stimulus: fetch read granted at cycle N, rst=1 at cycle N+1.
   - Required: f_rvalid=0 at N+1; burst_cnt=0 afterward.
6. ARB_RDATA_HOLD_EN:
   - Stimulus: fetch read returns 0xDEADBEEF, followed by 5 idle cycles in which mem_dout changes.
   - Required (macro defined): f_rdata stays 0xDEADBEEF.
   - Required (macro undefined): f_rdata tracks mem_dout.
